seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, registered successor to the 4-bit combinational add/sub pre-ALU.
- Adds arithmetic, logic, compare and shift ops, plus an iterative shift-add multiplier.
- Provides status flags and a start/busy/done handshake so a future datapath controller can sequence it.
- Sits between the operand register file and the writeback stage of the practice CPU datapath.

Parameters:
- WIDTH, 4, operand/result width in bits; legal values >= 2. The default matches the predecessor's 4-bit width.
- SHW, $clog2(WIDTH), shift-amount width. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- start  input  1  request; sampled only in IDLE
- op  input  3  operation select (encoding below)
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- busy  output  1  high while a multiply is iterating
- done  output  1  one-cycle pulse when C/C_hi/flags are updated
- C  output  WIDTH  result (low half for MUL)
- C_hi  output  WIDTH  high half of MUL product; 0 for all other ops
- zero  output  1  result == 0 (full 2*WIDTH product for MUL)
- carry  output  1  ADD: carry-out; SUB: borrow (A < B unsigned); 0 otherwise
- ovf  output  1  signed overflow for ADD/SUB; 0 otherwise
- neg  output  1  C[WIDTH-1] (C_hi[WIDTH-1] for MUL)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values: all outputs 0; state IDLE; internal accumulator and counter cleared.
- op encoding:
  - 000 ADD: C = A+B
  - 001 SUB: C = A-B
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLT: C = 1 if $signed(A) < $signed(B), else 0
  - 110 SLL: C = A << B[SHW-1:0]
  - 111 MUL: unsigned, {C_hi,C} = A*B
- Arithmetic: ADD/SUB use a WIDTH+1-bit internal sum. carry/borrow comes from bit WIDTH. ovf = operand signs equal (ADD) or different (SUB) and result sign differs from A.
- States: IDLE, MUL.
- IDLE, start=1, op != MUL:
  - At that edge, register result and flags; done=1 for the following cycle.
  - Latency 1; state stays IDLE.
- IDLE, start=1, op=MUL:
  - At that edge, latch A (multiplicand) and B (multiplier); clear accumulator and counter; busy=1; go to MUL.
- MUL:
  - Each edge: if multiplier LSB=1, add multiplicand to the upper accumulator half; shift the {carry, acc, multiplier} chain right by one; counter+1.
  - On the WIDTH-th iteration edge: write the product to {C_hi,C}, update flags, busy=0, done=1 for one cycle, return to IDLE.
  - MUL start at edge k gives done high in the cycle after edge k+WIDTH; busy is high for exactly WIDTH cycles.
- start while busy: ignored; operands and op changes during MUL have no effect.
- start on the cycle done is high: accepted normally (state is already IDLE). Back-to-back single-cycle ops give done high on consecutive cycles.
- Outputs hold their last value between completions. done is never high for more than one cycle per accepted start.
- start=0 in IDLE: no state change; outputs hold.
- rst_n=0 mid-multiply: at that edge abort, return to IDLE, clear all outputs. No done pulse for the aborted op.
- SLL with shift amount >= WIDTH: impossible by width truncation (mod 2^SHW). For non-power-of-two WIDTH, amounts >= WIDTH give C=0.

Test Plan (WIDTH=4):
1. Reset, then ADD A=9, B=7, start one cycle -> next cycle done=1, C=0, carry=1, zero=1, ovf=0, neg=0, C_hi=0.
2. SUB A=5, B=2 -> C=3, carry=0, ovf=0. Then SUB A=3, B=6 -> C=13, carry=1, neg=1, ovf=0. Issue these back-to-back -> done high two consecutive cycles.
3. ADD A=7, B=1 -> C=8, ovf=1, neg=1, carry=0. ADD A=15, B=7 -> C=6, carry=1, ovf=0.
4. MUL A=15, B=7:
   - busy=1 for 4 cycles; done pulses in the 4th cycle after the start edge; C_hi=6, C=9, zero=0.
   - Pulse start with ADD operands during busy -> ignored; no extra done pulse; result still 105.
5. SLT A=14 (-2), B=3 -> C=1. SLL A=3, B=2 -> C=12. AND/OR/XOR with A=12, B=10 -> C=8, 14, 6; carry=ovf=0.
6. Start MUL A=15, B=15; drive rst_n=0 at the 2nd iteration -> all outputs 0 next cycle, no done. Then ADD 1+1 -> C=2, proving clean restart.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with single-cycle ADD/SUB/AND/OR/XOR/SLT/SLL ops
// and an iterative shift-add unsigned multiplier.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   start, op        request (sampled only in IDLE), operation select
//   A, B             operands
//   busy             high while a multiply iterates
//   done             one-cycle pulse when C/C_hi/flags update
//   C, C_hi          result (C_hi = high half of MUL product, else 0)
//   zero, carry,     status flags for the most recent completion
//   ovf, neg
module seq_alu #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] C_hi,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             neg
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic [0:0]       state, state_n;
  logic [WIDTH-1:0] mcand, mcand_n;
  logic [WIDTH-1:0] mplier, mplier_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             busy_n, done_n, zero_n, carry_n, ovf_n, neg_n;
  logic [WIDTH-1:0] c_n, c_hi_n;

  // Single-cycle datapath
  logic [WIDTH:0]   add_sum, sub_sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry, alu_ovf;

  // One multiply step: conditional add into the upper half, then shift right
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_acc_nx, mul_mpl_nx;

  assign add_sum    = {1'b0, A} + {1'b0, B};
  assign sub_sum    = {1'b0, A} - {1'b0, B};
  assign mul_sum    = {1'b0, acc} + {1'b0, (mplier[0] ? mcand : WIDTH'(0))};
  assign mul_acc_nx = mul_sum[WIDTH:1];
  assign mul_mpl_nx = {mul_sum[0], mplier[WIDTH-1:1]};

  // Result and flag selection for non-multiply ops
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res   = add_sum[WIDTH-1:0];
        alu_carry = add_sum[WIDTH];
        alu_ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (add_sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = sub_sum[WIDTH-1:0];
        alu_carry = sub_sum[WIDTH];
        alu_ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (sub_sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_XOR:  alu_res = A ^ B;
      OP_SLT:  alu_res = ($signed(A) < $signed(B)) ? WIDTH'(1) : WIDTH'(0);
      // Amounts >= WIDTH (non power-of-two widths) shift everything out
      OP_SLL:  alu_res = A << B[SHW-1:0];
      default: alu_res = '0;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      C      <= '0;
      C_hi   <= '0;
      zero   <= 1'b0;
      carry  <= 1'b0;
      ovf    <= 1'b0;
      neg    <= 1'b0;
    end else begin
      state  <= state_n;
      mcand  <= mcand_n;
      mplier <= mplier_n;
      acc    <= acc_n;
      cnt    <= cnt_n;
      busy   <= busy_n;
      done   <= done_n;
      C      <= c_n;
      C_hi   <= c_hi_n;
      zero   <= zero_n;
      carry  <= carry_n;
      ovf    <= ovf_n;
      neg    <= neg_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n  = state;
    mcand_n  = mcand;
    mplier_n = mplier;
    acc_n    = acc;
    cnt_n    = cnt;
    busy_n   = busy;
    done_n   = 1'b0;
    c_n      = C;
    c_hi_n   = C_hi;
    zero_n   = zero;
    carry_n  = carry;
    ovf_n    = ovf;
    neg_n    = neg;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            mcand_n  = A;
            mplier_n = B;
            acc_n    = '0;
            cnt_n    = '0;
            busy_n   = 1'b1;
            state_n  = S_MUL;
          end else begin
            c_n     = alu_res;
            c_hi_n  = '0;
            zero_n  = (alu_res == '0);
            carry_n = alu_carry;
            ovf_n   = alu_ovf;
            neg_n   = alu_res[WIDTH-1];
            done_n  = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_n    = mul_acc_nx;
        mplier_n = mul_mpl_nx;
        cnt_n    = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          c_n     = mul_mpl_nx;
          c_hi_n  = mul_acc_nx;
          zero_n  = ({mul_acc_nx, mul_mpl_nx} == '0);
          carry_n = 1'b0;
          ovf_n   = 1'b0;
          neg_n   = mul_acc_nx[WIDTH-1];
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed self-checking bench for seq_alu at WIDTH=4.
// Observed vector layout: {busy, done, C_hi, C, zero, carry, ovf, neg}.
module tb_seq_alu;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] op;
  logic [3:0] A;
  logic [3:0] B;
  logic       busy;
  logic       done;
  logic [3:0] C;
  logic [3:0] C_hi;
  logic       zero;
  logic       carry;
  logic       ovf;
  logic       neg;

  int total = 0;
  int bad   = 0;

  logic [13:0] obs;
  assign obs = {busy, done, C_hi, C, zero, carry, ovf, neg};

  seq_alu #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .C(C), .C_hi(C_hi),
    .zero(zero), .carry(carry), .ovf(ovf), .neg(neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
  endtask

  task automatic test_reset();
    logic [13:0] exp;
    rst_n = 1'b0;
    start = 1'b0;
    op = 3'd0; A = 4'd0; B = 4'd0;
    step();
    step();
    exp = 14'b0;
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL reset: got %h want %h", obs, exp);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_add_zero_carry();
    logic [13:0] exp;
    set_op(3'b000, 4'd9, 4'd7);
    step();
    start = 1'b0;
    exp = {1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL add_9_7: got %h want %h", obs, exp);
    end
    step();
    exp = {1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL add_hold: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [13:0] exp;
    set_op(3'b001, 4'd5, 4'd2);
    step();
    exp = {1'b0, 1'b1, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL sub_5_2: got %h want %h", obs, exp);
    end
    set_op(3'b001, 4'd3, 4'd6);
    step();
    start = 1'b0;
    exp = {1'b0, 1'b1, 4'd0, 4'd13, 1'b0, 1'b1, 1'b0, 1'b1};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL sub_3_6: got %h want %h", obs, exp);
    end
    step();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL done_single: got %b want 0", done);
    end
  endtask

  task automatic test_add_ovf();
    logic [13:0] exp;
    set_op(3'b000, 4'd7, 4'd1);
    step();
    exp = {1'b0, 1'b1, 4'd0, 4'd8, 1'b0, 1'b0, 1'b1, 1'b1};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL add_7_1: got %h want %h", obs, exp);
    end
    set_op(3'b000, 4'd15, 4'd7);
    step();
    start = 1'b0;
    exp = {1'b0, 1'b1, 4'd0, 4'd6, 1'b0, 1'b1, 1'b0, 1'b0};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL add_15_7: got %h want %h", obs, exp);
    end
    step();
  endtask

  task automatic test_mul();
    logic [13:0] exp;
    int extra_done;
    set_op(3'b111, 4'd15, 4'd7);
    step();
    // Conflicting ADD request while the multiply runs must be ignored
    set_op(3'b000, 4'd1, 4'd1);
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL mul_busy0: got busy=%b done=%b want busy=1 done=0", busy, done);
    end
    extra_done = 0;
    for (int i = 1; i < 4; i++) begin
      step();
      start = 1'b0;
      if (done) extra_done++;
      total++;
      if (busy !== 1'b1) begin
        bad++;
        $display("FAIL mul_busy%0d: got %b want 1", i, busy);
      end
    end
    total++;
    if (extra_done !== 0) begin
      bad++;
      $display("FAIL mul_early_done: got %0d want 0", extra_done);
    end
    step();
    exp = {1'b0, 1'b1, 4'd6, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL mul_15_7: got %h want %h", obs, exp);
    end
    step();
    exp = {1'b0, 1'b0, 4'd6, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL mul_hold: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_logic();
    logic [3:0] ops [5]  = '{3'b101, 3'b110, 3'b010, 3'b011, 3'b100};
    logic [3:0] as  [5]  = '{4'd14, 4'd3, 4'd12, 4'd12, 4'd12};
    logic [3:0] bs  [5]  = '{4'd3, 4'd2, 4'd10, 4'd10, 4'd10};
    logic [3:0] cs  [5]  = '{4'd1, 4'd12, 4'd8, 4'd14, 4'd6};
    logic [13:0] exp;
    for (int i = 0; i < 5; i++) begin
      set_op(ops[i][2:0], as[i], bs[i]);
      step();
      start = 1'b0;
      exp = {1'b0, 1'b1, 4'd0, cs[i], 1'b0, 1'b0, 1'b0, cs[i][3]};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL logic_op%0d: got %h want %h", i, obs, exp);
      end
    end
    step();
  endtask

  task automatic test_abort();
    logic [13:0] exp;
    int seen_done;
    set_op(3'b111, 4'd15, 4'd15);
    step();
    start = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    exp = 14'b0;
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL abort_clear: got %h want %h", obs, exp);
    end
    rst_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done || busy) seen_done++;
    end
    total++;
    if (seen_done !== 0) begin
      bad++;
      $display("FAIL abort_no_done: got %0d want 0", seen_done);
    end
    set_op(3'b000, 4'd1, 4'd1);
    step();
    start = 1'b0;
    exp = {1'b0, 1'b1, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL restart_add: got %h want %h", obs, exp);
    end
  endtask

  initial begin
    test_reset();
    test_add_zero_carry();
    test_back_to_back();
    test_add_ovf();
    test_mul();
    test_logic();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
